// File: rtl/sprite_wr_pkg.sv
// Shared types and constants for the sprite RAM write engine.
package sprite_wr_pkg;

    typedef enum logic [1:0] {IDLE, BURST, FILL} wr_state_t;

    localparam logic OP_BURST = 1'b0;
    localparam logic OP_FILL  = 1'b1;

    localparam int unsigned WORD_WIDTH     = 32;
    localparam int unsigned PIX_WIDTH      = 2;
    localparam int unsigned PIX_PER_WORD   = WORD_WIDTH / PIX_WIDTH;
    localparam int unsigned CMD_ADDR_WIDTH = 10;

    typedef struct packed {
        logic                      op;
        logic [CMD_ADDR_WIDTH-1:0] addr;
        logic [WORD_WIDTH-1:0]     data;
    } cmd_t;

endpackage

// File: rtl/sprite_cmd_slot.sv
// One-entry command holding register: loads when the engine cannot take a command directly.
module sprite_cmd_slot
    import sprite_wr_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic clear,
    input  cmd_t cmd_in,
    output cmd_t cmd_out,
    output logic valid,
    output logic ready
);

    cmd_t cmd_q;
    logic valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            cmd_q   <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            cmd_q   <= cmd_in;
        end else if (clear) begin
            valid_q <= 1'b0;
        end
    end

    assign cmd_out = cmd_q;
    assign valid   = valid_q;
    // Reset gates ready combinationally so no command is taken while reset is held.
    assign ready   = ~valid_q & ~reset;

endmodule

// File: rtl/sprite_ram_loader.sv
// Turns BURST/FILL commands into one-pixel-per-cycle writes on the sprite RAM write port.
module sprite_ram_loader
    import sprite_wr_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = CMD_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = PIX_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_data,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] addr_w,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  busy,
    output logic                  done_tick
);

    localparam logic [ADDR_WIDTH-1:0] BurstLast = ADDR_WIDTH'(32 / DATA_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] FillLast  = '1;

    wr_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]           data_q, data_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  done_q, done_d;

    cmd_t new_cmd, pend_cmd, load_cmd;
    logic pend_valid, slot_ready;
    logic accept, final_wr, engine_free, load_eng, slot_load, slot_clear;

    assign new_cmd = '{op: cmd_op, addr: cmd_addr, data: cmd_data};
    assign accept  = cmd_valid & slot_ready;

    // The cycle whose write is on the port is the last one of the current command.
    assign final_wr    = ((state_q == BURST) && (cnt_q == BurstLast)) ||
                         ((state_q == FILL)  && (cnt_q == FillLast));
    assign engine_free = (state_q == IDLE) | final_wr;
    assign slot_load   = accept & ~engine_free;
    assign slot_clear  = final_wr & pend_valid;

    sprite_cmd_slot u_slot (
        .clk     (clk),
        .reset   (reset),
        .load    (slot_load),
        .clear   (slot_clear),
        .cmd_in  (new_cmd),
        .cmd_out (pend_cmd),
        .valid   (pend_valid),
        .ready   (slot_ready)
    );

    always_comb begin
        load_eng = 1'b0;
        load_cmd = new_cmd;
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        din_d    = din_q;
        done_d   = 1'b0;

        // A pending command always goes first; the slot is empty whenever a new one is accepted.
        if (final_wr && pend_valid) begin
            load_eng = 1'b1;
            load_cmd = pend_cmd;
        end else if (accept && engine_free) begin
            load_eng = 1'b1;
        end

        if (load_eng) begin
            state_d = (load_cmd.op == OP_FILL) ? FILL : BURST;
            cnt_d   = '0;
            data_d  = load_cmd.data;
            we_d    = 1'b1;
            addr_d  = (load_cmd.op == OP_FILL) ? '0 : load_cmd.addr;
            din_d   = load_cmd.data[DATA_WIDTH-1:0];
        end else if (final_wr) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                BURST: begin
                    cnt_d  = cnt_q + 1'b1;
                    we_d   = 1'b1;
                    addr_d = addr_q + 1'b1;
                    data_d = data_q >> DATA_WIDTH;
                    din_d  = data_q[2*DATA_WIDTH-1:DATA_WIDTH];
                    done_d = (cnt_q == BurstLast - 1'b1);
                end
                FILL: begin
                    cnt_d  = cnt_q + 1'b1;
                    we_d   = 1'b1;
                    addr_d = addr_q + 1'b1;
                    done_d = (cnt_q == FillLast - 1'b1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            done_q  <= done_d;
        end
    end

    assign cmd_ready = slot_ready;
    assign we        = we_q;
    assign addr_w    = addr_q;
    assign din       = din_q;
    assign done_tick = done_q;
    assign busy      = (state_q != IDLE) | pend_valid;

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Self-checking bench for sprite_ram_loader: vector table, corner sequences, random commands.
module tb_sprite_ram_loader;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic [9:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        we;
    logic [9:0]  addr_w;
    logic [1:0]  din;
    logic        busy;
    logic        done_tick;

    sprite_ram_loader dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .we        (we),
        .addr_w    (addr_w),
        .din       (din),
        .busy      (busy),
        .done_tick (done_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] addr;
        logic [1:0] din;
        logic       done;
    } wr_t;

    typedef struct {
        logic        op;
        logic [9:0]  addr;
        logic [31:0] data;
        logic [9:0]  exp_last_addr;
        logic [1:0]  exp_last_din;
    } vec_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [1:0] ram [1024];

    int n_vec = 0;
    int n_err = 0;
    int wr_total = 0;
    int done_cnt = 0;
    int run = 0;
    int max_run = 0;
    logic [9:0] last_done_addr = '0;
    logic [1:0] last_done_din = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Expected write stream of one command, straight from the command semantics.
    task automatic push_model(input logic op, input logic [9:0] addr, input logic [31:0] data);
        wr_t w;
        if (op) begin
            for (int i = 0; i < 1024; i++) begin
                w.addr = 10'(i);
                w.din  = data[1:0];
                w.done = (i == 1023);
                exp_q.push_back(w);
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                w.addr = 10'((int'(addr) + i) % 1024);
                w.din  = 2'((data >> (2 * i)) & 32'h3);
                w.done = (i == 15);
                exp_q.push_back(w);
            end
        end
    endtask

    always @(negedge clk) begin
        if (we) begin
            ram[addr_w] = din;
            wr_total++;
            run++;
            if (run > max_run) max_run = run;
            if (done_tick) begin
                done_cnt++;
                last_done_addr = addr_w;
                last_done_din  = din;
            end
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_write: got write addr %0h din %0d, required none",
                         addr_w, din);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 32'(addr_w), 32'(mon_e.addr));
                check("wr_din", 32'(din), 32'(mon_e.din));
                check("wr_done_tick", 32'(done_tick), 32'(mon_e.done));
            end
        end else begin
            run = 0;
            if (done_tick) begin
                n_vec++;
                n_err++;
                $display("FAIL done_without_we: got done_tick 1, required 0");
            end
        end
    end

    // Called just after a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic op, input logic [9:0] addr, input logic [31:0] data);
        int  waited;
        bit  was_idle;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_valid = 1'b1;
        waited    = 0;
        while (!cmd_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            fail_now("send_ready_wait");
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        was_idle = (exp_q.size() == 0);
        push_model(op, addr, data);
        @(negedge clk);
        if (was_idle) begin
            check("first_write_we", 32'(we), 32'd1);
            check("first_write_addr", 32'(addr_w), op ? 32'd0 : 32'(addr));
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || we) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy || we) fail_now("wait_idle");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs [5];
    int   base_done, base_wr, n, low, busy_bad, bad, fills;
    logic [31:0] d2, d3;
    logic        r_op;

    initial begin
        vecs[0] = '{1'b0, 10'h010, 32'hE4E4_E4E4, 10'h01F, 2'd3};
        vecs[1] = '{1'b0, 10'h3F8, 32'h1234_5678, 10'h007, 2'd0};
        vecs[2] = '{1'b0, 10'h3FF, 32'h8000_0000, 10'h00E, 2'd2};
        vecs[3] = '{1'b0, 10'h000, 32'h5555_5555, 10'h00F, 2'd1};
        vecs[4] = '{1'b0, 10'h123, 32'h4000_0000, 10'h132, 2'd1};

        // Reset held with a command offered.
        reset     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 1'b0;
        cmd_addr  = 10'h155;
        cmd_data  = 32'hFFFF_FFFF;
        repeat (3) begin
            @(negedge clk);
            check("rst_we", 32'(we), 32'd0);
            check("rst_addr_w", 32'(addr_w), 32'd0);
            check("rst_din", 32'(din), 32'd0);
            check("rst_done_tick", 32'(done_tick), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        reset     = 1'b0;
        #1;
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // Single commands from the table.
        for (int vi = 0; vi < 5; vi++) begin
            base_done = done_cnt;
            send(vecs[vi].op, vecs[vi].addr, vecs[vi].data);
            cmd_valid = 1'b0;
            wait_idle();
            check("vec_done_count", 32'(done_cnt - base_done), 32'd1);
            check("vec_last_addr", 32'(last_done_addr), 32'(vecs[vi].exp_last_addr));
            check("vec_last_din", 32'(last_done_din), 32'(vecs[vi].exp_last_din));
        end

        // Three back-to-back BURSTs with cmd_valid held high.
        @(negedge clk);
        max_run   = 0;
        base_done = done_cnt;
        d2 = $urandom;
        d3 = $urandom;
        send(1'b0, 10'h040, $urandom);
        send(1'b0, 10'h080, d2);
        check("b2b_ready_low_after_2nd", 32'(cmd_ready), 32'd0);
        cmd_op   = 1'b0;
        cmd_addr = 10'h0C0;
        cmd_data = d3;
        low = 0;
        while (!cmd_ready && low < 100) begin
            @(negedge clk);
            low++;
        end
        check("b2b_ready_low_cycles", 32'(low), 32'd15);
        check("b2b_ready_rise_we", 32'(we), 32'd1);
        check("b2b_ready_rise_addr", 32'(addr_w), 32'h080);
        @(posedge clk);
        push_model(1'b0, 10'h0C0, d3);
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle();
        check("b2b_contiguous_we", 32'(max_run), 32'd48);
        check("b2b_done_pulses", 32'(done_cnt - base_done), 32'd3);

        // FILL with colour 3 over a cleared model RAM.
        for (int i = 0; i < 1024; i++) ram[i] = 2'd0;
        base_done = done_cnt;
        send(1'b1, 10'h2AB, {$urandom} | 32'h3);
        cmd_valid = 1'b0;
        busy_bad = 0;
        n = 0;
        while (exp_q.size() != 0 && n < 1100) begin
            if (!busy) busy_bad++;
            @(negedge clk);
            #1;
            n++;
        end
        check("fill_busy_low_cycles", 32'(busy_bad), 32'd0);
        wait_idle();
        check("fill_done_count", 32'(done_cnt - base_done), 32'd1);
        check("fill_last_addr", 32'(last_done_addr), 32'h3FF);
        bad = 0;
        for (int i = 0; i < 1024; i++) if (ram[i] !== 2'd3) bad++;
        check("fill_ram_entries_not_3", 32'(bad), 32'd0);

        // Reset after 5 writes of a BURST with another BURST pending.
        @(negedge clk);
        base_done = done_cnt;
        base_wr   = wr_total;
        send(1'b0, 10'h100, $urandom);
        send(1'b0, 10'h300, $urandom);
        cmd_valid = 1'b0;
        n = 0;
        while ((wr_total - base_wr) < 5 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("midrst_writes_before", 32'(wr_total - base_wr), 32'd5);
        check("midrst_slot_full", 32'(cmd_ready), 32'd0);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_we_drop", 32'(we), 32'd0);
        check("midrst_done_tick", 32'(done_tick), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_no_done", 32'(done_cnt - base_done), 32'd0);
        send(1'b0, 10'h200, $urandom);
        cmd_valid = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk);
        check("midrst_new_done", 32'(done_cnt - base_done), 32'd1);
        check("midrst_new_last_addr", 32'(last_done_addr), 32'h20F);

        // Random command stream checked against the model.
        fills = 0;
        for (int r = 0; r < 30; r++) begin
            r_op = 1'b0;
            if (fills == 0 && $urandom_range(0, 14) == 0) begin
                r_op = 1'b1;
                fills++;
            end
            send(r_op, 10'($urandom_range(0, 1023)), $urandom);
            if ($urandom_range(0, 1) == 1) begin
                cmd_valid = 1'b0;
                repeat ($urandom_range(0, 20)) @(negedge clk);
            end
        end
        cmd_valid = 1'b0;
        wait_idle();
        repeat (5) @(negedge clk);
        check("random_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
